// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle for imm_gen_pipe
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [2:0]      in_imm_src;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_imm_src, out_ready,
        output in_ready, out_valid, out_imm, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_imm_src, out_ready,
        input  in_ready, out_valid, out_imm, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate extender with one-entry skid buffer
// Optional IMM_GEN_AUTO_FMT_EN: derive the format from the opcode instead of in_imm_src.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    imm_gen_pipe_if.slave bus
);
    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [2:0] FMT_I  = 3'd0;
    localparam logic [2:0] FMT_S  = 3'd1;
    localparam logic [2:0] FMT_B  = 3'd2;
    localparam logic [2:0] FMT_U  = 3'd3;
    localparam logic [2:0] FMT_J  = 3'd4;
    localparam logic [2:0] FMT_Z  = 3'd5;
    localparam logic [2:0] FMT_SH = 3'd6;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    logic [31:0]     ins;
    logic [2:0]      fmt;
    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;

    assign ins = bus.in_instr;

`ifdef IMM_GEN_AUTO_FMT_EN
    logic unused_imm_src;
    assign unused_imm_src = ^bus.in_imm_src;

    always_comb begin
        fmt = 3'd7;
        case (ins[6:0])
            7'b0010011: fmt = (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) ? FMT_SH : FMT_I;
            7'b0000011,
            7'b1100111: fmt = FMT_I;
            7'b0100011: fmt = FMT_S;
            7'b1100011: fmt = FMT_B;
            7'b0110111,
            7'b0010111: fmt = FMT_U;
            7'b1101111: fmt = FMT_J;
            7'b1110011: fmt = ins[14] ? FMT_Z : FMT_I;
            default:    fmt = 3'd7;
        endcase
    end
`else
    assign fmt = bus.in_imm_src;
`endif

    always_comb begin
        dec_imm = '0;
        dec_ill = 1'b0;
        case (fmt)
            FMT_I:  dec_imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
            FMT_S:  dec_imm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:  dec_imm = {{(XLEN-12){ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:  dec_imm = {{(XLEN-31){ins[31]}}, ins[30:12], 12'b0};
            FMT_J:  dec_imm = {{(XLEN-20){ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            FMT_Z:  dec_imm = {{(XLEN-5){1'b0}}, ins[19:15]};
            FMT_SH: dec_imm = (XLEN == 64) ? {{(XLEN-6){1'b0}}, ins[25:20]}
                                           : {{(XLEN-5){1'b0}}, ins[24:20]};
            default: dec_ill = 1'b1;
        endcase
    end

    state_t          state_q, state_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
    logic            out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;
    logic            accept, drain;

    // Occupancy is the state: in_ready and out_valid are decoded straight from state_q.
    assign accept = bus.in_valid && (state_q != S_TWO);
    assign drain  = (state_q != S_EMPTY) && bus.out_ready;

    always_comb begin
        state_d    = state_q;
        out_imm_d  = out_imm_q;
        out_ill_d  = out_ill_q;
        skid_imm_d = skid_imm_q;
        skid_ill_d = skid_ill_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    out_imm_d = dec_imm;
                    out_ill_d = dec_ill;
                    state_d   = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && drain) begin
                    out_imm_d = dec_imm;
                    out_ill_d = dec_ill;
                end else if (accept) begin
                    skid_imm_d = dec_imm;
                    skid_ill_d = dec_ill;
                    state_d    = S_TWO;
                end else if (drain) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (drain) begin
                    out_imm_d = skid_imm_q;
                    out_ill_d = skid_ill_q;
                    state_d   = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            out_imm_q  <= '0;
            out_ill_q  <= 1'b0;
            skid_imm_q <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_imm_q  <= out_imm_d;
            out_ill_q  <= out_ill_d;
            skid_imm_q <= skid_imm_d;
            skid_ill_q <= skid_ill_d;
        end
    end

    assign bus.in_ready    = (state_q != S_TWO);
    assign bus.out_valid   = (state_q != S_EMPTY);
    assign bus.out_imm     = out_imm_q;
    assign bus.out_illegal = out_ill_q;
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate extender.
- Registers the decoded immediate behind a valid/ready handshake with a one-entry skid buffer, giving full throughput under backpressure.
- Supports XLEN 32 or 64, plus two extra formats: CSR zimm and shift-amount.
- Sits between the fetch/decode register and the execute operand mux.

Parameters:
- XLEN, 32, datapath width of `imm`; legal values are 32 and 64. Any other value is a fatal elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept an instruction this cycle.
- in_instr  in  32  raw instruction word.
- in_imm_src  in  3  format select: 0=I, 1=S, 2=B, 3=U, 4=J, 5=Z (CSR zimm), 6=SH (shamt), 7=reserved.
- out_valid  out  1  `out_imm` is valid.
- out_ready  in  1  downstream accepts this cycle.
- out_imm  out  XLEN  extended immediate.
- out_illegal  out  1  the selected format was reserved (7).

Behaviour:
- Reset is asynchronous: `rst` clears state immediately, independent of `clk`.
  - `out_valid`=0, `out_imm`=0, `out_illegal`=0, `in_ready`=1, skid buffer empty.
  - Any instruction in flight is dropped.
- Handshake:
  - Transfer in when `in_valid` && `in_ready`; transfer out when `out_valid` && `out_ready`.
  - `out_valid` must stay asserted and `out_imm`/`out_illegal` must stay stable until accepted.
- Latency: an accepted instruction appears on `out_imm` on the next rising edge (1 cycle) when the output register is free or being drained that cycle.
- Skid buffer:
  - `in_ready` is driven from a register: `in_ready` = skid buffer empty.
  - If an input is accepted while the output register is held (`out_valid`=1, `out_ready`=0), the decoded result goes to the skid buffer and `in_ready` drops next cycle.
  - When the output drains, the skid entry moves to the output register and `in_ready` returns to 1.
  - Order is strictly preserved; no beat is lost or duplicated.
  - Simultaneous input accept and output drain with an empty skid buffer: the new beat replaces the output register directly, and `out_valid` stays 1.
- States (implicit in occupancy): EMPTY (`out_valid`=0), ONE (output full, skid empty), TWO (both full, `in_ready`=0).
  - EMPTY→ONE on input.
  - ONE→ONE on input plus drain.
  - ONE→TWO on input without drain.
  - ONE→EMPTY on drain without input.
  - TWO→ONE on drain.
- Decode (combinational before the register); sign bit is `instr[31]`, sign-extended to XLEN:
  - I: sign-extend `instr[31:20]`.
  - S: sign-extend {`instr[31:25]`, `instr[11:7]`}.
  - B: sign-extend {`instr[31]`, `instr[7]`, `instr[30:25]`, `instr[11:8]`, 0}.
  - U: {`instr[31:12]`, 12'b0}; for XLEN=64, sign-extended from bit 31.
  - J: sign-extend {`instr[31]`, `instr[19:12]`, `instr[20]`, `instr[30:21]`, 0}.
  - Z: zero-extend `instr[19:15]`.
  - SH: zero-extend `instr[25:20]` for XLEN=64; zero-extend `instr[24:20]` for XLEN=32.
  - Reserved (7): `imm`=0, `out_illegal`=1.

Optional Feature:
- Macro: IMM_GEN_AUTO_FMT_EN.
- Defined:
  - `in_imm_src` is ignored; the format is derived from opcode `instr[6:0]`.
  - Mapping: 0010011/0000011/1100111 → I; 0100011 → S; 1100011 → B; 0110111/0010111 → U; 1101111 → J.
  - 1110011 with `funct3`[2]=1 → Z; 1110011 with `funct3`[2]=0 → I.
  - 0010011 with `funct3` 001/101 → SH.
  - Any other opcode → reserved, so `out_illegal`=1.
- Undefined: the format comes from `in_imm_src` exactly as above.
- Port list is identical in both builds.

Test Plan:
- XLEN=32, I, `in_instr`=0xFFF00093, `out_ready`=1 → next cycle `out_valid`=1, `out_imm`=0xFFFFFFFF, `out_illegal`=0.
- XLEN=32, B, `in_instr`=0xFE000EE3 → `out_imm`=0xFFFFFFFC; J with `in_instr`=0x0080006F → `out_imm`=0x00000008.
- XLEN=64, U, `in_instr`=0x800000B7 → `out_imm`=0xFFFFFFFF80000000; SH with `in_instr`=0x03F09093 → `out_imm`=0x3F.
- Backpressure: 3 back-to-back beats (I values 1, 2, 3), `out_ready`=0 for 3 cycles → `in_ready`=0 after the second beat, `out_imm` holds 1 stable; after release, outputs are 1, 2, 3 in consecutive cycles.
- Reserved format 7 with any instruction → `out_imm`=0, `out_illegal`=1; with IMM_GEN_AUTO_FMT_EN, opcode 0110011 also gives `out_illegal`=1.
- `rst` asserted mid-cycle while in state TWO → immediately `out_valid`=0 and `out_imm`=0; `in_ready`=1 without waiting for a clock edge.
